// File: rtl/uart_pkg.sv
// Shared UART constants: byte width, RX FIFO defaults and status bit indices
// used by both the RX FIFO and the UART register decode.
package uart_pkg;
  localparam int UART_BYTE_W        = 8;
  localparam int UART_RX_DEPTH_LOG2 = 4;
  localparam int UART_RX_TIMEOUT    = 17360;
  localparam int UART_IDLE_CNT_W    = 16;
  localparam int STAT_OVERRUN       = 0;
  localparam int STAT_FRAME         = 1;
endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Register array for the RX FIFO: one synchronous write port and one
// combinational read port addressed by independent pointers.
module uart_rx_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = UART_RX_DEPTH_LOG2
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [DEPTH_LOG2-1:0]  waddr,
  input  logic [UART_BYTE_W-1:0] wdata,
  input  logic [DEPTH_LOG2-1:0]  raddr,
  output logic [UART_BYTE_W-1:0] rdata
);

  logic [UART_BYTE_W-1:0] r_mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Show-ahead RX byte FIFO with sticky overrun/framing flags and idle timeout.
// Optional threshold interrupt enabled by defining UART_RX_FIFO_THRESH_IRQ_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2     = UART_RX_DEPTH_LOG2,
  parameter int TIMEOUT_CYCLES = UART_RX_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rxc_in,
  input  logic                   rx_err_in,
  input  logic [UART_BYTE_W-1:0] rx_byte_in,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [1:0]             err_clr,
  output logic [UART_BYTE_W-1:0] rd_byte,
  output logic                   empty,
  output logic                   full,
  output logic [DEPTH_LOG2:0]    level,
  output logic                   overrun,
  output logic                   frame_err,
  output logic                   rx_timeout
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
  ,
  input  logic [DEPTH_LOG2:0]    thresh,
  output logic                   rx_irq
`endif
);

  localparam logic [DEPTH_LOG2:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [UART_IDLE_CNT_W-1:0] TO_MAX = UART_IDLE_CNT_W'(TIMEOUT_CYCLES);

  logic [DEPTH_LOG2-1:0]      r_wptr, r_rptr;
  logic [DEPTH_LOG2:0]        r_level;
  logic                       r_overrun, r_frame_err, r_timeout;
  logic [UART_IDLE_CNT_W-1:0] r_idle;

  logic                   w_empty, w_full, w_push, w_pop, w_ovf;
  logic [UART_BYTE_W-1:0] w_rdata;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == DEPTH);
  // When full, a same-cycle pop frees the slot the push lands in.
  assign w_push  = rxc_in & (~w_full | pop) & ~flush;
  assign w_pop   = pop & ~w_empty & ~flush;
  assign w_ovf   = rxc_in & w_full & ~pop & ~flush;

  uart_rx_fifo_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .clk   (clk),
    .wr_en (w_push),
    .waddr (r_wptr),
    .wdata (rx_byte_in),
    .raddr (r_rptr),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle wins over the clear strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_ovf)                      r_overrun <= 1'b1;
      else if (err_clr[STAT_OVERRUN]) r_overrun <= 1'b0;
      if (rx_err_in)                  r_frame_err <= 1'b1;
      else if (err_clr[STAT_FRAME])   r_frame_err <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= (r_idle == TO_MAX) & ~w_empty;
      if (w_push | w_pop | flush | w_empty) r_idle <= '0;
      else if (r_idle != TO_MAX)            r_idle <= r_idle + 1'b1;
    end
  end

`ifdef UART_RX_FIFO_THRESH_IRQ_EN
  logic r_irq;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_irq <= 1'b0;
    else     r_irq <= ((r_level >= thresh) & (thresh != '0)) |
                      r_timeout | r_overrun | r_frame_err;
  end
  assign rx_irq = r_irq;
`endif

  assign rd_byte    = w_empty ? '0 : w_rdata;
  assign empty      = w_empty;
  assign full       = w_full;
  assign level      = r_level;
  assign overrun    = r_overrun;
  assign frame_err  = r_frame_err;
  assign rx_timeout = r_timeout;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int DL  = 4;
  localparam int D   = 16;
  localparam int TO  = 50;

  logic       clk, rst, rxc_in, rx_err_in, pop, flush;
  logic [7:0] rx_byte_in;
  logic [1:0] err_clr;
  logic [7:0] rd_byte;
  logic       empty, full, overrun, frame_err, rx_timeout;
  logic [DL:0] level;

  int nchk = 0;
  int nerr = 0;

  // reference model state
  logic [7:0] q[$];
  bit m_ovr, m_fe, m_to;
  int m_idle;

  uart_rx_fifo #(.DEPTH_LOG2(DL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rxc_in(rxc_in), .rx_err_in(rx_err_in),
    .rx_byte_in(rx_byte_in), .pop(pop), .flush(flush), .err_clr(err_clr),
    .rd_byte(rd_byte), .empty(empty), .full(full), .level(level),
    .overrun(overrun), .frame_err(frame_err), .rx_timeout(rx_timeout)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete(); m_ovr = 0; m_fe = 0; m_to = 0; m_idle = 0;
  endtask

  // one clock: drive inputs, advance model at the edge, sample 1ns later
  task automatic cyc(input bit c, input logic [7:0] b, input bit p,
                     input bit f, input logic [1:0] clr, input bit e);
    bit was_full, was_empty, pushed, popped;
    rxc_in = c; rx_byte_in = b; pop = p; flush = f; err_clr = clr; rx_err_in = e;
    @(posedge clk);
    was_full  = (q.size() == D);
    was_empty = (q.size() == 0);
    pushed = 0; popped = 0;
    m_to = (m_idle == TO) && !was_empty;
    if (f) q.delete();
    else begin
      if (p && !was_empty) begin void'(q.pop_front()); popped = 1; end
      if (c && (!was_full || p)) begin q.push_back(b); pushed = 1; end
    end
    if (c && was_full && !p && !f) m_ovr = 1;
    else if (clr[0]) m_ovr = 0;
    if (e) m_fe = 1;
    else if (clr[1]) m_fe = 0;
    if (pushed || popped || f || was_empty) m_idle = 0;
    else if (m_idle < TO) m_idle++;
    #1;
    rxc_in = 0; pop = 0; flush = 0; err_clr = 0; rx_err_in = 0;
  endtask

  task automatic test_reset();
    nchk++; if (level !== 0 || empty !== 1 || full !== 0 || rd_byte !== 0) begin
      nerr++; $display("FAIL reset_fifo: level=%0d empty=%0b full=%0b rd=%0h exp 0/1/0/0", level, empty, full, rd_byte);
    end
    nchk++; if (overrun !== 0 || frame_err !== 0 || rx_timeout !== 0) begin
      nerr++; $display("FAIL reset_flags: ovr=%0b fe=%0b to=%0b exp 0", overrun, frame_err, rx_timeout);
    end
  endtask

  task automatic test_basic();
    cyc(1, 8'h41, 0, 0, 0, 0);
    cyc(1, 8'h42, 0, 0, 0, 0);
    cyc(1, 8'h43, 0, 0, 0, 0);
    nchk++; if (level !== 3 || rd_byte !== 8'h41) begin
      nerr++; $display("FAIL basic_fill: level=%0d rd=%0h exp 3/41", level, rd_byte);
    end
    cyc(0, 0, 1, 0, 0, 0);
    nchk++; if (rd_byte !== 8'h42) begin nerr++; $display("FAIL basic_pop1: rd=%0h exp 42", rd_byte); end
    cyc(0, 0, 1, 0, 0, 0);
    nchk++; if (rd_byte !== 8'h43) begin nerr++; $display("FAIL basic_pop2: rd=%0h exp 43", rd_byte); end
    cyc(0, 0, 1, 0, 0, 0);
    nchk++; if (empty !== 1 || rd_byte !== 0 || level !== 0) begin
      nerr++; $display("FAIL basic_pop3: empty=%0b rd=%0h level=%0d exp 1/0/0", empty, rd_byte, level);
    end
    cyc(0, 0, 1, 0, 0, 0);
    nchk++; if (empty !== 1 || level !== 0) begin
      nerr++; $display("FAIL pop_empty: empty=%0b level=%0d exp 1/0", empty, level);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 17; i++) cyc(1, 8'(i), 0, 0, 0, 0);
    nchk++; if (full !== 1 || level !== 16 || overrun !== 1) begin
      nerr++; $display("FAIL overflow: full=%0b level=%0d ovr=%0b exp 1/16/1", full, level, overrun);
    end
    for (int i = 0; i < 16; i++) begin
      nchk++; if (rd_byte !== 8'(i)) begin nerr++; $display("FAIL overflow_order[%0d]: rd=%0h exp %0h", i, rd_byte, i); end
      cyc(0, 0, 1, 0, 0, 0);
    end
    nchk++; if (empty !== 1 || rd_byte !== 0 || overrun !== 1) begin
      nerr++; $display("FAIL overflow_drain: empty=%0b rd=%0h ovr=%0b exp 1/0/1", empty, rd_byte, overrun);
    end
  endtask

  task automatic test_full_pushpop();
    cyc(0, 0, 0, 1, 2'b11, 0);
    for (int i = 0; i < 16; i++) cyc(1, 8'h20 + 8'(i), 0, 0, 0, 0);
    cyc(1, 8'hAA, 1, 0, 0, 0);
    nchk++; if (overrun !== 0 || level !== 16 || full !== 1) begin
      nerr++; $display("FAIL full_pushpop: ovr=%0b level=%0d full=%0b exp 0/16/1", overrun, level, full);
    end
    for (int i = 0; i < 15; i++) begin
      nchk++; if (rd_byte !== 8'h21 + 8'(i)) begin nerr++; $display("FAIL full_pushpop_order[%0d]: rd=%0h exp %0h", i, rd_byte, 8'h21 + i); end
      cyc(0, 0, 1, 0, 0, 0);
    end
    nchk++; if (rd_byte !== 8'hAA || level !== 1) begin
      nerr++; $display("FAIL full_pushpop_last: rd=%0h level=%0d exp AA/1", rd_byte, level);
    end
    cyc(0, 0, 1, 0, 0, 0);
  endtask

  task automatic test_timeout();
    cyc(0, 0, 0, 1, 2'b11, 0);
    cyc(1, 8'h55, 0, 0, 0, 0);
    for (int i = 0; i < TO; i++) cyc(0, 0, 0, 0, 0, 0);
    nchk++; if (rx_timeout !== 0 || m_to !== 0) begin
      nerr++; $display("FAIL timeout_early: to=%0b model=%0b exp 0", rx_timeout, m_to);
    end
    cyc(0, 0, 0, 0, 0, 0);
    nchk++; if (rx_timeout !== 1 || m_to !== 1) begin
      nerr++; $display("FAIL timeout_fire: to=%0b model=%0b exp 1", rx_timeout, m_to);
    end
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    nchk++; if (rx_timeout !== 0 || empty !== 1) begin
      nerr++; $display("FAIL timeout_pop: to=%0b empty=%0b exp 0/1", rx_timeout, empty);
    end
    for (int i = 0; i < 3 * TO; i++) cyc(0, 0, 0, 0, 0, 0);
    nchk++; if (rx_timeout !== 0) begin nerr++; $display("FAIL timeout_empty_idle: to=%0b exp 0", rx_timeout); end
  endtask

  task automatic test_flags_flush();
    cyc(0, 0, 0, 0, 2'b10, 1);
    nchk++; if (frame_err !== 1) begin nerr++; $display("FAIL frame_set_wins: fe=%0b exp 1", frame_err); end
    cyc(0, 0, 0, 0, 2'b10, 0);
    nchk++; if (frame_err !== 0) begin nerr++; $display("FAIL frame_clear: fe=%0b exp 0", frame_err); end
    for (int i = 0; i < 5; i++) cyc(1, 8'h60 + 8'(i), 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 8'h99, 1, 1, 0, 0);
    nchk++; if (level !== 0 || empty !== 1 || rd_byte !== 0 || frame_err !== 1) begin
      nerr++; $display("FAIL flush: level=%0d empty=%0b rd=%0h fe=%0b exp 0/1/0/1", level, empty, rd_byte, frame_err);
    end
    cyc(0, 0, 0, 0, 2'b11, 0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 17; i++) cyc(1, 8'h70 + 8'(i), 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 0, 1, 0, 0, 0);
    nchk++; if (level !== 7 || overrun !== 1) begin
      nerr++; $display("FAIL pre_reset: level=%0d ovr=%0b exp 7/1", level, overrun);
    end
    #2 rst = 1;
    #1;
    model_reset();
    nchk++; if (level !== 0 || empty !== 1 || full !== 0 || rd_byte !== 0 || overrun !== 0 || frame_err !== 0 || rx_timeout !== 0) begin
      nerr++; $display("FAIL async_reset: level=%0d empty=%0b full=%0b rd=%0h ovr=%0b fe=%0b to=%0b", level, empty, full, rd_byte, overrun, frame_err, rx_timeout);
    end
    #1 rst = 0;
    cyc(1, 8'h33, 0, 0, 0, 0);
    nchk++; if (rd_byte !== 8'h33 || level !== 1) begin
      nerr++; $display("FAIL post_reset_push: rd=%0h level=%0d exp 33/1", rd_byte, level);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      bit c, p, f, e;
      logic [1:0] clr;
      c   = ($urandom_range(0, 99) < 55);
      p   = ($urandom_range(0, 99) < 40);
      f   = ($urandom_range(0, 99) < 2);
      e   = ($urandom_range(0, 99) < 4);
      clr = ($urandom_range(0, 99) < 8) ? 2'($urandom) : 2'b00;
      cyc(c, 8'($urandom), p, f, clr, e);
      nchk++;
      if (level !== (DL+1)'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == D) ||
          rd_byte !== ((q.size() != 0) ? q[0] : 8'h00) || overrun !== m_ovr ||
          frame_err !== m_fe || rx_timeout !== m_to) begin
        nerr++;
        $display("FAIL random[%0d]: level=%0d/%0d rd=%0h/%0h ovr=%0b/%0b fe=%0b/%0b to=%0b/%0b (dut/model)",
                 n, level, q.size(), rd_byte, (q.size() != 0) ? q[0] : 8'h00,
                 overrun, m_ovr, frame_err, m_fe, rx_timeout, m_to);
      end
    end
  endtask

  initial begin
    rst = 1; rxc_in = 0; rx_err_in = 0; rx_byte_in = 0; pop = 0; flush = 0; err_clr = 0;
    model_reset();
    #23;
    test_reset();
    rst = 0;
    test_basic();
    test_overflow();
    test_full_pushpop();
    test_timeout();
    test_flags_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
